bitvault_arbiter: RTL
=====================

// Module: bitvault_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer for the single-port bitvault_regfile (4 x 8-bit).
//  Requesters A and B each issue single-word read/write ops.
//  The arbiter serialises them onto the regfile's we/addr/data_in port.
//  It returns read data with a registered valid pulse.
//  Sits between the two client engines and one bitvault_regfile instance.
// PARAMETERS
//  DATA_W  8  regfile word width
//  ADDR_W  2  regfile address width (2^ADDR_W entries)
// PORTS
//  clk       in   1       system clock, rising edge
//  rst_n     in   1       asynchronous active-low reset
//  a_req     in   1       A requests an op; hold with a_we/a_addr/a_wdata stable until a_gnt
//  a_we      in   1       1 = write, 0 = read
//  a_addr    in   ADDR_W  A target address
//  a_wdata   in   DATA_W  A write data
//  a_gnt     out  1       one-cycle pulse: A's op is on the regfile this cycle
//  a_rvalid  out  1       one-cycle pulse: a_rdata holds A's read result
//  a_rdata   out  DATA_W  A read data (held until next A read completes)
//  b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata   same as A, for requester B
//  rf_we     out  1       to regfile we
//  rf_addr   out  ADDR_W  to regfile addr
//  rf_wdata  out  DATA_W  to regfile data_in
//  rf_rdata  in   DATA_W  from regfile data_out (combinational read)
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE, rr_last=B (so A has first priority).
//    - rf_we=0, rf_addr=0, rf_wdata=0; gnt/rvalid=0; rdata=0.
//    - rf_we must drop in the same instant rst_n falls (gated by state, not a later edge).
//  - FSM states: IDLE, SERVE.
//  - IDLE: if any req in cycle N, pick the winner, latch its we/addr/wdata/id, go to SERVE at N+1.
//    - If no req, stay in IDLE.
//  - SERVE (cycle N+1):
//    - rf_we=latched we, rf_addr/rf_wdata=latched values; gnt of the winner=1.
//    - A write commits at the posedge ending N+1.
//    - For a read, rf_rdata is captured into x_rdata at that edge; x_rvalid=1 in cycle N+2 only.
//  - Arbitration in SERVE: the currently granted port's req is masked (its owner drops req after gnt).
//    - If the other port requests, go SERVE->SERVE back-to-back with the new winner.
//    - Otherwise return to IDLE.
//  - Round-robin: on simultaneous A and B, the port not equal to rr_last wins.
//    - rr_last updates to the winner on every grant.
//  - Latency: req->gnt 1 cycle; gnt->rvalid 1 cycle; peak throughput 1 op/cycle when A and B alternate.
//  - Outside SERVE: rf_we=0; rf_addr/rf_wdata hold their last values (no spurious writes).
//  - Read-after-write: an op served in a later cycle sees data committed by an earlier write.
//  - a_rvalid and b_gnt may be high in the same cycle; each port's signals are independent.
//  - Write ops never assert rvalid.
//  - A req dropped before gnt is protocol misuse.
//    - The latched op still executes; the bench must not rely on this.
//  - Reset mid-SERVE aborts the op: no gnt, no rvalid; regfile contents are not reset by this block.
// TESTING
//  - Reset: rst_n=0 while idle -> rf_we=0, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
//  - A-only writes, then reads:
//    - A writes 0xAA@0, 0x55@1, 0xF0@2, 0x0F@3 -> each a_gnt one cycle after a_req, rf_we high exactly that cycle.
//    - A then reads 0..3 -> a_rvalid the cycle after a_gnt, a_rdata = AA, 55, F0, 0F.
//  - Contention after reset: A writes 0x99@1 and B reads @1, both requesting in the same cycle:
//    - a_gnt first; b_gnt the next cycle (back-to-back).
//    - b_rvalid with b_rdata=0x99.
//  - Fairness: both ports re-request continuously for 8 ops -> grants strictly alternate A,B,A,B...
//    - No idle cycles; rr_last correct.
//  - Read does not modify: B reads @1 (0x99) while b_wdata=0x33 -> rf_we=0; a later read @1 returns 0x99.
//  - Reset mid-op: assert rst_n=0 during a SERVE cycle of A's write 0x77@2:
//    - rf_we falls immediately; no a_gnt/a_rvalid.
//    - After release, a read @2 returns the prior value 0xF0.

Source files
------------

// File: rtl/bitvault_arbiter_if.sv
// Purpose : signal bundle between the two requesters (A, B), the arbiter and
//           the single-port bitvault_regfile.
// Ports   : a_*/b_*  per-requester request (req/we/addr/wdata) and response
//                    (gnt/rvalid/rdata)
//           rf_*     regfile port (we/addr/wdata out of arbiter, rdata back)
// Modports: slave  = arbiter side
//           master = environment side (requesters + regfile)
interface bitvault_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_gnt;
   logic              a_rvalid;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_gnt;
   logic              b_rvalid;
   logic [DATA_W-1:0] b_rdata;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rf_rdata;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_gnt, a_rvalid, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_gnt, b_rvalid, b_rdata,
      output rf_we, rf_addr, rf_wdata,
      input  rf_rdata
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_gnt, a_rvalid, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  rf_we, rf_addr, rf_wdata,
      output rf_rdata
   );
endinterface

// File: rtl/bitvault_arbiter.sv
// Purpose : two-port round-robin arbiter/sequencer for a single-port 4x8
//           regfile. Each requester issues single-word read/write ops; the
//           winner is latched in IDLE/SERVE and presented to the regfile for
//           one cycle (gnt pulse). Read data is captured at the end of the
//           SERVE cycle and returned with a one-cycle rvalid pulse.
// Ports   : clk    system clock, rising edge
//           rst_n  asynchronous active-low reset
//           bus    bitvault_arbiter_if.slave (requesters A/B + regfile port)
module bitvault_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   bitvault_arbiter_if.slave   bus
);

   typedef enum logic {ST_IDLE, ST_SERVE} state_t;
   typedef enum logic {PORT_A, PORT_B}    port_t;

   state_t            r_state;
   port_t             r_id;
   port_t             r_rr_last;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_a_rvalid;
   logic              r_b_rvalid;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;

   logic w_serving;
   logic w_a_elig;
   logic w_b_elig;
   logic w_any;
   logic w_pick_b;

   assign w_serving = (r_state == ST_SERVE);

   // The port being served this cycle has already been granted, so its req
   // is ignored; this lets the other port win back-to-back.
   assign w_a_elig = bus.a_req && !(w_serving && (r_id == PORT_A));
   assign w_b_elig = bus.b_req && !(w_serving && (r_id == PORT_B));
   assign w_any    = w_a_elig || w_b_elig;

   always_comb begin
      w_pick_b = 1'b0;
      if (w_a_elig && w_b_elig)
         w_pick_b = (r_rr_last == PORT_A);
      else
         w_pick_b = w_b_elig;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_id       <= PORT_A;
         r_rr_last  <= PORT_B;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
      end else begin
         r_a_rvalid <= w_serving && !r_we && (r_id == PORT_A);
         r_b_rvalid <= w_serving && !r_we && (r_id == PORT_B);
         if (w_serving && !r_we) begin
            if (r_id == PORT_A)
               r_a_rdata <= bus.rf_rdata;
            else
               r_b_rdata <= bus.rf_rdata;
         end

         if (w_any) begin
            r_state   <= ST_SERVE;
            r_id      <= w_pick_b ? PORT_B : PORT_A;
            r_rr_last <= w_pick_b ? PORT_B : PORT_A;
            r_we      <= w_pick_b ? bus.b_we    : bus.a_we;
            r_addr    <= w_pick_b ? bus.b_addr  : bus.a_addr;
            r_wdata   <= w_pick_b ? bus.b_wdata : bus.a_wdata;
         end else begin
            r_state   <= ST_IDLE;
         end
      end
   end

   // Strobes are decoded from the (asynchronously reset) state register so
   // they drop the instant rst_n falls, not at the next edge.
   assign bus.rf_we    = w_serving && r_we;
   assign bus.rf_addr  = r_addr;
   assign bus.rf_wdata = r_wdata;
   assign bus.a_gnt    = w_serving && (r_id == PORT_A);
   assign bus.b_gnt    = w_serving && (r_id == PORT_B);
   assign bus.a_rvalid = r_a_rvalid;
   assign bus.b_rvalid = r_b_rvalid;
   assign bus.a_rdata  = r_a_rdata;
   assign bus.b_rdata  = r_b_rdata;

endmodule
